// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - funct3 codes, FSM states and lane constants for the data-memory access unit
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LANE0 = 2'b00;
  localparam logic [1:0] LANE1 = 2'b01;
  localparam logic [1:0] LANE2 = 2'b10;
  localparam logic [1:0] LANE3 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Loads accept B/H/W/BU/HU; stores only B/H/W.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfword accesses ignore addr[0], word accesses ignore addr[1:0].
  function automatic logic [31:0] force_align(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] a;
    a = addr;
    case (f3)
      F3_H, F3_HU: a = {addr[31:1], 1'b0};
      F3_W:        a = {addr[31:2], 2'b00};
      default:     a = addr;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational load extract/extend and sub-word store merge
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      LANE0:   b = word[7:0];
      LANE1:   b = word[15:8];
      LANE2:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] m;
    m = old_word;
    case (f3)
      F3_B: begin
        case (lane)
          LANE0:   m[7:0]   = data[7:0];
          LANE1:   m[15:8]  = data[7:0];
          LANE2:   m[23:16] = data[7:0];
          default: m[31:24] = data[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) m[31:16] = data[15:0];
        else         m[15:0]  = data[15:0];
      end
      default: m = data;
    endcase
    return m;
  endfunction

  // Both results are pure functions of the current word and access descriptor.
  always_comb begin
    load_data_o   = load_extract(word_i, lane_i, funct3_i);
    merged_word_o = store_merge(word_i, store_data_i, lane_i, funct3_i);
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory initiator; MISALIGN_TRAP_EN selects trap vs force-align
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_resp_valid,
  output logic [31:0] o_load_data,
  output logic        o_err,
  output logic        o_misaligned,
  output logic        o_stb,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_write_data,
  input  logic        i_rd_ack,
  input  logic [31:0] i_read_data
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              store_q, store_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_q, load_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic [31:0]       ext_load;
  logic [31:0]       merged_word;
  logic [CNT_W-1:0]  cnt_inc;
  logic              mis_c;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // The read word is used directly on the ack cycle, so no separate capture register is needed.
  mem_lane_align u_align (
    .word_i        (i_read_data),
    .lane_i        (addr_q[1:0]),
    .funct3_i      (f3_q),
    .store_data_i  (sdata_q),
    .load_data_o   (ext_load),
    .merged_word_o (merged_word)
  );

  // Misalignment: either trapped, or the offending low address bits are simply dropped.
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    mis_c = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: mis_c = i_addr[0];
      F3_W:        mis_c = (i_addr[1:0] != 2'b00);
      default:     mis_c = 1'b0;
    endcase
`else
    mis_c = 1'b0;
`endif
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      sdata_q <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state: request decode, ack/timeout handling, read-modify-write sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    store_d = store_q;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    err_d   = err_q;
    mis_d   = mis_q;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          f3_d    = i_funct3;
          store_d = i_is_store;
          sdata_d = i_store_data;
          cnt_d   = '0;
          load_d  = '0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
          addr_d  = i_addr;
`else
          addr_d  = force_align(i_addr, i_funct3);
`endif
          if (!f3_legal(i_is_store, i_funct3)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (mis_c) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else if (i_is_store && (i_funct3 == F3_W)) begin
            wdata_d = i_store_data;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d = cnt_inc;
        if (i_rd_ack) begin
          if (store_q) begin
            wdata_d = merged_word;
            state_d = S_WR;
          end else begin
            load_d  = ext_load;
            state_d = S_RESP;
          end
        end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state; response fields are forced to zero outside RESP.
  always_comb begin
    o_req_ready  = (state_q == S_IDLE) && !rst;
    o_stb        = (state_q == S_RD);
    o_wr_en      = (state_q == S_WR);
    o_addr       = (o_stb || o_wr_en) ? {addr_q[31:2], 2'b00} : 32'h0;
    o_write_data = o_wr_en ? wdata_q : 32'h0;
    o_resp_valid = (state_q == S_RESP);
    o_load_data  = o_resp_valid ? load_q : 32'h0;
    o_err        = o_resp_valid && err_q;
    o_misaligned = o_resp_valid && mis_q;
  end

endmodule
